// File: rtl/ps2_receiver.sv
// Purpose : PS/2 keyboard receiver; deserialises device frames, drops break/E0 codes, reports make codes.
// Latency : raw ps2_clk fall -> internal fall strobe ~2+FILTER_LEN clocks; tasta/done/err update 1 clock after stop-bit fall.
// Backpr. : none; free-running with no ready input, done is stretched for DONE_HOLD clocks so a slow sampler cannot miss it.
//
// Ports:
//   clock    - system clock (pixel clock)
//   reset    - asynchronous active-low reset
//   ps2_clk  - raw PS/2 clock from pad (asynchronous)
//   ps2_data - raw PS/2 data from pad (asynchronous)
//   tasta    - last accepted make scan code (held until the next make code)
//   done     - high for DONE_HOLD clocks after each accepted make code
//   err      - one-clock pulse on framing, parity or timeout error
module ps2_receiver #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int DONE_HOLD  = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] tasta,
    output logic       done,
    output logic       err
);

    localparam int FC_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(DONE_HOLD + 1);

    localparam logic [FC_W-1:0]   FC_MAX   = FC_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_VAL = HOLD_W'(DONE_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Line conditioning: index 0 = ps2_clk, index 1 = ps2_data.
    logic [1:0]      meta;
    logic [1:0]      sync;
    logic [1:0]      filt;
    logic [FC_W-1:0] fcnt [2];
    logic            filt_clk_q;
    logic            fall;
    logic            data_bit;

    state_t             state, state_nxt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               par_bit;
    logic [WD_W-1:0]    wd_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               brk;

    logic frame_ok;
    logic frame_bad;
    logic to_err;
    logic is_make;

    // Lines idle high, so every conditioning stage resets to 1 to avoid a
    // spurious fall strobe coming out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta       <= 2'b11;
            sync       <= 2'b11;
            filt       <= 2'b11;
            filt_clk_q <= 1'b1;
            fcnt[0]    <= '0;
            fcnt[1]    <= '0;
        end else begin
            meta       <= {ps2_data, ps2_clk};
            sync       <= meta;
            filt_clk_q <= filt[0];
            // Any sample equal to the current filtered level restarts the
            // run, so only FILTER_LEN consecutive differing samples flip it.
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FC_MAX) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FC_W'(1);
                end
            end
        end
    end

    assign fall     = filt_clk_q & ~filt[0];
    assign data_bit = filt[1];

    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        to_err    = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_bit) state_nxt = DATA;
            end
            DATA: begin
                if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
                if (fall) state_nxt = STOP;
            end
            STOP: begin
                if (fall) begin
                    state_nxt = IDLE;
                    // Odd parity over data+parity, and stop bit must be 1.
                    if ((^{shift, par_bit}) && data_bit) frame_ok = 1'b1;
                    else                                 frame_bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Watchdog: only a frame in progress can be abandoned.
        if (state != IDLE && !fall && wd_cnt == WD_MAX) begin
            state_nxt = IDLE;
            to_err    = 1'b1;
        end
    end

    assign is_make = frame_ok && (shift != CODE_BRK) && (shift != CODE_EXT) && !brk;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            wd_cnt   <= '0;
            hold_cnt <= '0;
            brk      <= 1'b0;
            tasta    <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= frame_bad | to_err;

            if (state == IDLE || fall || to_err) wd_cnt <= '0;
            else                                 wd_cnt <= wd_cnt + WD_W'(1);

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            shift   <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= data_bit;
                    default: ;
                endcase
            end

            // E0 leaves brk alone; any other byte after F0 is the swallowed
            // break target, which also clears brk.
            if (frame_ok) begin
                if (shift == CODE_BRK)      brk <= 1'b1;
                else if (shift != CODE_EXT) brk <= 1'b0;
            end

            if (is_make) begin
                tasta    <= shift;
                done     <= 1'b1;
                hold_cnt <= HOLD_VAL;
            end else if (done) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
                if (hold_cnt == HOLD_ONE) done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
module tb_ps2_receiver;

    localparam int FL = 2;
    localparam int TO = 200;
    localparam int DH = 50;

    localparam int K_MAKE   = 0;
    localparam int K_ERR    = 1;
    localparam int K_ERR_TO = 2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] tasta;
    logic       done;
    logic       err;

    ps2_receiver #(
        .FILTER_LEN(FL),
        .TIMEOUT   (TO),
        .DONE_HOLD (DH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .tasta   (tasta),
        .done    (done),
        .err     (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int vectors     = 0;
    int miscompares = 0;
    int last_fall   = 0;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Device drives data while clock is high, host samples on the fall.
    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(20);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        tick(20);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        tick(60);
    endtask

    // Monitor: pops one expected event per done/err rising edge.
    logic done_q = 1'b0;
    logic err_q  = 1'b0;
    int   done_w = 0;
    int   err_w  = 0;

    always @(negedge clock) begin
        exp_t e;
        int   d;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                check("done_kind", e.kind, K_MAKE);
                check("tasta_at_done", tasta, e.val);
            end
            done_w = 1;
        end else if (done) begin
            done_w++;
        end
        if (!done && done_q) check("done_width", done_w, DH);

        if (err && !err_q) begin
            if (sb.size() == 0) begin
                check("unexpected_err", err, 0);
            end else begin
                e = sb.pop_front();
                check("err_kind_not_make", (e.kind == K_MAKE), 0);
                if (e.kind == K_ERR_TO) begin
                    d = cyc - last_fall;
                    check("timeout_delay_in_window", (d >= 198 && d <= 212), 1);
                end
            end
            err_w = 1;
        end else if (err) begin
            err_w++;
        end
        if (!err && err_q) check("err_width", err_w, 1);

        if (err && done) check("err_done_overlap", err & done, 0);

        done_q = done;
        err_q  = err;
    end

    initial begin
        logic [7:0] b1e;

        // Reset state
        reset = 1'b0;
        tick(5);
        check("rst_tasta", tasta, 8'h00);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        tick(20);

        // Single make code
        push(K_MAKE, 8'h1C);
        send_frame(8'h1C, 0, 0, 11);
        check("t1_tasta", tasta, 8'h1C);

        // Make then break sequence
        push(K_MAKE, 8'h29);
        send_frame(8'h29, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h29, 0, 0, 11);
        check("t2_tasta", tasta, 8'h29);
        check("t2_done_low", done, 0);

        // Parity error then stop-bit error
        push(K_ERR, 8'h00);
        send_frame(8'h76, 1, 0, 11);
        push(K_ERR, 8'h00);
        send_frame(8'h76, 0, 1, 11);
        check("t3_tasta", tasta, 8'h29);

        // Partial frame abandoned by the watchdog, then recovery
        push(K_ERR_TO, 8'h00);
        send_frame(8'h55, 0, 0, 5);
        tick(260);
        push(K_MAKE, 8'h16);
        send_frame(8'h16, 0, 0, 11);
        check("t4_tasta", tasta, 8'h16);

        // Idle glitches on ps2_clk, then extended-prefix make code
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            tick(1);
            ps2_clk = 1'b1;
            tick(10);
        end
        send_frame(8'hE0, 0, 0, 11);
        push(K_MAKE, 8'h75);
        send_frame(8'h75, 0, 0, 11);
        check("t5_tasta", tasta, 8'h75);

        // Reset mid-frame after 5 bits
        b1e = 8'h1E;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b1e[i]);
        reset = 1'b0;
        tick(3);
        check("t6_rst_tasta", tasta, 8'h00);
        check("t6_rst_done", done, 0);
        check("t6_rst_err", err, 0);
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(20);
        push(K_MAKE, 8'h1E);
        send_frame(8'h1E, 0, 0, 11);
        check("t6_tasta", tasta, 8'h1E);

        tick(100);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
